pattern_lut_cclut_rw: RTL and testbench
=======================================

Name: pattern_lut_cclut_rw

Overview:
- Parametrised successor of the CCLUT pattern lookup stage in the pattern finder.
- Serves NCH CLCT candidates per bx, each carrying a pattern ID and a comparator-code (carry) address.
- Each candidate's pattern ID selects one of NPID runtime-writable LUTs. The selected LUT returns the key-offset, bend and (optionally) quality fields.
- LUTs are initialised by hardware after reset and can be rewritten or read back by the slow-control host without stopping triggering.

Parameters:
- NCH, 2, number of CLCT lookup channels.
- NPID, 5, number of LUTs; pattern IDs PID_BASE..PID_BASE+NPID-1 map to LUT 0..NPID-1.
- PID_BASE, 6, lowest valid pattern ID. Default maps pid 6..A to LUT 0..4.
- MXPIDB, 4, pattern-ID width.
- MXADRB, 12, carry/comparator-code address width.
- MXOFFSB, 4, offset field width.
- MXBNDB, 5, bend field width: 4-bit magnitude, MSB = L/R sign.
- MXQLTB, 9, quality field width.
- OFFS_DEFAULT, 7, offset written during init (7 = zero half-strip offset).

Ports:
- clock, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, lookup request this cycle.
- pid, in, NCH*MXPIDB, per-channel pattern ID.
- carry, in, NCH*MXADRB, per-channel LUT address.
- out_valid, out, 1, lookup result valid.
- offs, out, NCH*MXOFFSB, per-channel offset.
- bend, out, NCH*MXBNDB, per-channel bend.
- quality, out, NCH*MXQLTB, per-channel quality.
- pid_miss, out, NCH, pid outside the mapped range; the channel's fields are 0.
- host_req, in, 1, host access request; held until host_ack.
- host_wr, in, 1, 1 = write, 0 = read.
- host_lut, in, 3, LUT index.
- host_adr, in, MXADRB, entry address.
- host_wdata, in, MXOFFSB+MXBNDB+MXQLTB, write data {offs,bend,quality}.
- host_rdata, out, MXOFFSB+MXBNDB+MXQLTB, read data; valid with host_ack.
- host_ack, out, 1, one-cycle completion pulse.
- init_busy, out, 1, hardware initialisation in progress.

Behaviour:
- Storage:
  - Each LUT holds one copy per channel, NCH copies total.
  - Each copy is a simple dual-port RAM: port B serves channel lookups; port A serves host/init writes.
  - One extra copy per LUT serves host reads.
- Async reset values:
  - All outputs = 0, except init_busy = 1.
  - Pipeline valid bits cleared.
  - FSM state = INIT, init counter = 0.
- FSM states: INIT, IDLE, HWRITE, HREAD, ACK.
  - INIT:
    - Writes {OFFS_DEFAULT, 0, 0} to address = counter in every copy of every LUT, one address per cycle.
    - Leaves for IDLE when counter = 2^MXADRB-1. INIT therefore lasts 2^MXADRB cycles.
    - init_busy drops on entering IDLE.
    - host_req is ignored (no ack).
    - out_valid is forced 0.
  - IDLE:
    - host_req & host_wr goes to HWRITE; host_req & !host_wr goes to HREAD.
    - host_lut >= NPID: go directly to ACK. Writes are dropped; reads return host_rdata = 0.
  - HWRITE: writes host_wdata to host_adr in all copies of host_lut, then goes to ACK.
  - HREAD: issues the read to the host copy, then goes to ACK.
  - ACK:
    - host_ack = 1 for exactly one cycle; host_rdata is registered and held until the next read.
    - Returns to IDLE. Requires host_req to drop before a new access is accepted (no back-to-back on a held request).
- Lookup:
  - Latency is 2 clocks from in_valid to out_valid.
  - Stage 1 reads all LUTs at carry (RAM registered output).
  - Stage 2 registers the pid-selected result; pid is delayed 1 clock to match.
  - Fully pipelined: a new request is accepted every cycle.
- Collision: a host write and a lookup to the same LUT/address in the same cycle is read-first; the lookup returns the old value.
- Reset mid-operation:
  - Aborts any host access with no ack.
  - Discards in-flight lookups.
  - Restarts INIT at address 0.
- Without CCLUT_QUALITY_EN: quality is always 0 and quality bits are not stored; host_wdata quality bits are ignored.

Optional Feature:
- Macro: CCLUT_QUALITY_EN.
- Defined: quality bits are stored in the LUT RAMs and output per channel.
- Undefined: RAM width = MXOFFSB+MXBNDB; the quality outputs are tied to 0; host_rdata quality bits read 0.

Decomposition:
- Shared package cclut_pkg holds:
  - MXPIDB, MXADRB, MXOFFSB, MXBNDB, MXQLTB.
  - The PID_BASE mapping.
  - The LUT entry typedef {offs,bend,quality}.
  - The FSM state enum.
- One sub-module: cclut_dpram (parametrised simple dual-port RAM, registered read).

Test Plan:
- Reset release -> init_busy = 1 for 4096 cycles, then 0. A lookup at any pid 6..A, any carry, returns offs = 7, bend = 0, quality = 0, with out_valid exactly 2 cycles after in_valid.
- Host write LUT 2, adr 0x123, data offs = 0xB, bend = 0x13 -> host_ack pulse. A subsequent lookup pid 8, carry 0x123 returns offs = 0xB, bend = 0x13 on every channel.
- Host read LUT 2, adr 0x123 after the above -> host_rdata = written value with host_ack. Read with host_lut = 6 -> ack with rdata = 0.
- Lookups pid = 5 and pid = 0xB -> pid_miss = 1, fields = 0. Other channels in the same cycle are unaffected.
- Same-cycle write and lookup to LUT 0, adr 0x010 -> lookup returns the old value; a lookup one cycle later returns the new value.
- Assert reset_n low mid-HWRITE -> no host_ack. init_busy = 1, and the entry reads default after re-init completes.

Source files
------------

// File: rtl/cclut_pkg.sv
// Shared definitions for the CCLUT pattern lookup stage.
//
// Contents: field widths, default pid mapping, LUT entry type, host/init FSM
// state codes and small helpers converting between the full entry and the
// word actually stored in the LUT RAMs.
//
// Build option: CCLUT_QUALITY_EN
//   defined   -> the quality field is stored in the RAMs (word = full entry)
//   undefined -> RAM word is {offs,bend}; quality always reads back as 0
package cclut_pkg;

  localparam int MXPIDB       = 4;   // pattern-ID width
  localparam int MXADRB       = 12;  // comparator-code (carry) address width
  localparam int MXOFFSB      = 4;   // key-offset field width
  localparam int MXBNDB       = 5;   // bend: 4-bit magnitude + L/R sign in MSB
  localparam int MXQLTB       = 9;   // quality field width
  localparam int PID_BASE_DEF = 6;   // pid 6..A -> LUT 0..4
  localparam int NPID_DEF     = 5;

  localparam int ENTRYB = MXOFFSB + MXBNDB + MXQLTB;
`ifdef CCLUT_QUALITY_EN
  localparam int RAMB = ENTRYB;
`else
  localparam int RAMB = MXOFFSB + MXBNDB;
`endif

  typedef struct packed {
    logic [MXOFFSB-1:0] offs;
    logic [MXBNDB-1:0]  bend;
    logic [MXQLTB-1:0]  quality;
  } lut_entry_t;

  // Host/init FSM state codes.
  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_HWRITE = 3'd2;
  localparam logic [2:0] ST_HREAD  = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

  // LUT index for a pattern ID; negative or >= NPID means unmapped.
  function automatic int pid_to_lut(input logic [MXPIDB-1:0] pid, input int base);
    return int'(pid) - base;
  endfunction

  function automatic lut_entry_t word_to_entry(input logic [RAMB-1:0] w);
`ifdef CCLUT_QUALITY_EN
    return lut_entry_t'(w);
`else
    return lut_entry_t'({w, {MXQLTB{1'b0}}});
`endif
  endfunction

  // Quality sits in the LSBs, so the stored word is simply the top RAMB bits.
  function automatic logic [RAMB-1:0] entry_to_word(input lut_entry_t e);
    return e[ENTRYB-1 -: RAMB];
  endfunction

endpackage

// File: rtl/pattern_lut_cclut_rw_if.sv
// Slow-control host access bus for pattern_lut_cclut_rw.
//
// Handshake: the master raises host_req with host_wr/host_lut/host_adr/
// host_wdata stable and holds them until host_ack. host_ack is a one-cycle
// pulse; on a read host_rdata is valid with it and is held until the next
// read. The master must drop host_req before a new access is taken; a request
// still high after its ack is never served twice.
//
// Signals: host_req, host_wr, host_lut[2:0], host_adr[MXADRB], host_wdata,
// host_rdata ({offs,bend,quality}), host_ack, fsm_state (debug view of the
// host/init FSM).
interface pattern_lut_cclut_rw_if;
  import cclut_pkg::*;

  logic              host_req;
  logic              host_wr;
  logic [2:0]        host_lut;
  logic [MXADRB-1:0] host_adr;
  logic [ENTRYB-1:0] host_wdata;
  logic [ENTRYB-1:0] host_rdata;
  logic              host_ack;
  logic [2:0]        fsm_state;

  modport master (
    output host_req, host_wr, host_lut, host_adr, host_wdata,
    input  host_rdata, host_ack, fsm_state
  );

  modport slave (
    input  host_req, host_wr, host_lut, host_adr, host_wdata,
    output host_rdata, host_ack, fsm_state
  );

endinterface

// File: rtl/cclut_dpram.sv
// Simple dual-port RAM, one write port (A) and one registered read port (B).
//
// Ports: clock; we_a/adr_a/din_a write port; re_b/adr_b read port with
// dout_b registered and held while re_b is low.
// A write and a read to the same address on one edge return the old data.
module cclut_dpram #(
  parameter int W  = 9,
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          we_a,
  input  logic [AW-1:0] adr_a,
  input  logic [W-1:0]  din_a,
  input  logic          re_b,
  input  logic [AW-1:0] adr_b,
  output logic [W-1:0]  dout_b
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clock) begin
    if (we_a) mem[adr_a] <= din_a;
    if (re_b) dout_b <= mem[adr_b];
  end

endmodule

// File: rtl/pattern_lut_cclut_rw.sv
// CCLUT pattern lookup stage with runtime-writable LUTs.
//
// Each of NCH channels presents a pattern ID and carry address per bx; the
// pid selects one of NPID LUTs, which returns {offs,bend,quality}. Result
// appears two clocks after in_valid. After reset the FSM fills every LUT with
// {OFFS_DEFAULT,0,0} (init_busy high), then serves host reads/writes through
// the hif bus without stalling lookups.
//
// Ports: clock, reset_n (async, active low), in_valid/pid/carry lookup input,
// out_valid/offs/bend/quality/pid_miss lookup output, init_busy, hif host bus.
// Build option: CCLUT_QUALITY_EN (store and output the quality field).
module pattern_lut_cclut_rw
  import cclut_pkg::*;
#(
  parameter int                 NCH          = 2,
  parameter int                 NPID         = NPID_DEF,
  parameter int                 PID_BASE     = PID_BASE_DEF,
  parameter logic [MXOFFSB-1:0] OFFS_DEFAULT = MXOFFSB'(7)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [NCH*MXPIDB-1:0]    pid,
  input  logic [NCH*MXADRB-1:0]    carry,
  output logic                     out_valid,
  output logic [NCH*MXOFFSB-1:0]   offs,
  output logic [NCH*MXBNDB-1:0]    bend,
  output logic [NCH*MXQLTB-1:0]    quality,
  output logic [NCH-1:0]           pid_miss,
  output logic                     init_busy,
  pattern_lut_cclut_rw_if.slave    hif
);

  logic [2:0]        state;
  logic [MXADRB-1:0] init_cnt;
  logic [2:0]        cap_lut;
  logic [MXADRB-1:0] cap_adr;
  lut_entry_t        cap_wdata;
  logic [2:0]        rd_lut;
  logic              rd_zero;    // last read targeted an unmapped LUT (or none yet)
  logic              wait_drop;  // access served, waiting for host_req to fall
  logic              host_lut_ok;

  lut_entry_t        init_entry;
  logic [MXADRB-1:0] wr_adr;
  logic [RAMB-1:0]   wr_word;
  logic [NPID-1:0]   wr_en;
  logic [NPID-1:0]   hrd_en;
  logic [RAMB-1:0]   lk_q [NPID][NCH];
  logic [RAMB-1:0]   hq   [NPID];

  assign host_lut_ok   = int'(hif.host_lut) < NPID;
  assign init_entry    = '{offs: OFFS_DEFAULT, bend: '0, quality: '0};
  assign init_busy     = (state == ST_INIT);
  assign hif.host_ack  = (state == ST_ACK);
  assign hif.fsm_state = state;

  // ---------------- host / init FSM ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      cap_lut   <= '0;
      cap_adr   <= '0;
      cap_wdata <= '0;
      rd_lut    <= '0;
      rd_zero   <= 1'b1;
      wait_drop <= 1'b0;
    end else begin
      if (!hif.host_req) wait_drop <= 1'b0;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == '1) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (hif.host_req && !wait_drop) begin
            wait_drop <= 1'b1;
            cap_lut   <= hif.host_lut;
            cap_adr   <= hif.host_adr;
            cap_wdata <= hif.host_wdata;
            if (!hif.host_wr) begin
              rd_lut  <= hif.host_lut;
              rd_zero <= !host_lut_ok;
            end
            if (!host_lut_ok)     state <= ST_ACK;
            else if (hif.host_wr) state <= ST_HWRITE;
            else                  state <= ST_HREAD;
          end
        end
        ST_HWRITE: state <= ST_ACK;
        ST_HREAD:  state <= ST_ACK;
        ST_ACK:    state <= ST_IDLE;
        default:   state <= ST_INIT;
      endcase
    end
  end

  // Port A of every copy is shared by init fill and host writes.
  always_comb begin
    wr_adr  = (state == ST_INIT) ? init_cnt : cap_adr;
    wr_word = (state == ST_INIT) ? entry_to_word(init_entry) : entry_to_word(cap_wdata);
    wr_en   = '0;
    hrd_en  = '0;
    for (int l = 0; l < NPID; l++) begin
      wr_en[l]  = (state == ST_INIT) || ((state == ST_HWRITE) && (int'(cap_lut) == l));
      hrd_en[l] = (state == ST_HREAD) && (int'(cap_lut) == l);
    end
  end

  // ---------------- LUT storage: NCH lookup copies + 1 host-read copy ----------------
  for (genvar l = 0; l < NPID; l++) begin : g_lut
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      cclut_dpram #(.W(RAMB), .AW(MXADRB)) u_lk (
        .clock  (clock),
        .we_a   (wr_en[l]),
        .adr_a  (wr_adr),
        .din_a  (wr_word),
        .re_b   (in_valid),
        .adr_b  (carry[c*MXADRB +: MXADRB]),
        .dout_b (lk_q[l][c])
      );
    end
    cclut_dpram #(.W(RAMB), .AW(MXADRB)) u_host (
      .clock  (clock),
      .we_a   (wr_en[l]),
      .adr_a  (wr_adr),
      .din_a  (wr_word),
      .re_b   (hrd_en[l]),
      .adr_b  (cap_adr),
      .dout_b (hq[l])
    );
  end

  // Host read data: RAM output registers hold between reads, so no extra flop.
  lut_entry_t rd_entry;
  always_comb begin
    rd_entry = '0;
    for (int l = 0; l < NPID; l++)
      if (int'(rd_lut) == l) rd_entry = word_to_entry(hq[l]);
  end
  assign hif.host_rdata = rd_zero ? '0 : rd_entry;

  // ---------------- lookup pipeline ----------------
  logic                  v1;
  logic [NCH*MXPIDB-1:0] pid_d1;
  logic [NCH*MXOFFSB-1:0] sel_offs;
  logic [NCH*MXBNDB-1:0]  sel_bend;
  logic [NCH*MXQLTB-1:0]  sel_qlt;
  logic [NCH-1:0]         sel_miss;

  always_comb begin
    int         idx;
    lut_entry_t e;
    sel_offs = '0;
    sel_bend = '0;
    sel_qlt  = '0;
    sel_miss = '0;
    for (int c = 0; c < NCH; c++) begin
      idx = pid_to_lut(pid_d1[c*MXPIDB +: MXPIDB], PID_BASE);
      e   = '0;
      sel_miss[c] = (idx < 0) || (idx >= NPID);
      for (int l = 0; l < NPID; l++)
        if (idx == l) e = word_to_entry(lk_q[l][c]);
      sel_offs[c*MXOFFSB +: MXOFFSB] = e.offs;
      sel_bend[c*MXBNDB  +: MXBNDB]  = e.bend;
      sel_qlt [c*MXQLTB  +: MXQLTB]  = e.quality;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      pid_d1    <= '0;
      out_valid <= 1'b0;
      offs      <= '0;
      bend      <= '0;
      quality   <= '0;
      pid_miss  <= '0;
    end else begin
      v1        <= in_valid && (state != ST_INIT);
      pid_d1    <= pid;
      out_valid <= v1 && (state != ST_INIT);
      if (v1) begin
        offs     <= sel_offs;
        bend     <= sel_bend;
        quality  <= sel_qlt;
        pid_miss <= sel_miss;
      end
    end
  end

endmodule

// File: tb/tb_pattern_lut_cclut_rw.sv
// Testbench for pattern_lut_cclut_rw: table vectors, hand sequences for
// collision / held request / reset abort, and randomized lookups and host
// accesses checked against an array model of the LUT contents.
`timescale 1ns/1ps
module tb_pattern_lut_cclut_rw;
  import cclut_pkg::*;

  localparam int NCH      = 2;
  localparam int NPID     = 5;
  localparam int PID_BASE = 6;
  localparam int DEPTH    = 1 << MXADRB;
  localparam int EW       = NCH * (1 + ENTRYB);
`ifdef CCLUT_QUALITY_EN
  localparam logic [MXQLTB-1:0] QMASK = '1;
`else
  localparam logic [MXQLTB-1:0] QMASK = '0;
`endif

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic                   in_valid;
  logic [NCH*MXPIDB-1:0]  pid;
  logic [NCH*MXADRB-1:0]  carry;
  logic                   out_valid;
  logic [NCH*MXOFFSB-1:0] offs;
  logic [NCH*MXBNDB-1:0]  bend;
  logic [NCH*MXQLTB-1:0]  quality;
  logic [NCH-1:0]         pid_miss;
  logic                   init_busy;

  pattern_lut_cclut_rw_if hif();

  pattern_lut_cclut_rw #(.NCH(NCH), .NPID(NPID), .PID_BASE(PID_BASE)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .pid       (pid),
    .carry     (carry),
    .out_valid (out_valid),
    .offs      (offs),
    .bend      (bend),
    .quality   (quality),
    .pid_miss  (pid_miss),
    .init_busy (init_busy),
    .hif       (hif)
  );

  // ---------------- reference model & scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [ENTRYB-1:0] model [NPID][DEPTH];
  logic [EW-1:0]     exp_q[$];
  int                iss_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NPID; l++)
      for (int a = 0; a < DEPTH; a++)
        model[l][a] = {4'd7, 5'd0, 9'd0};
  endtask

  function automatic logic [ENTRYB-1:0] stored(input logic [ENTRYB-1:0] d);
    return {d[17:9], d[8:0] & QMASK};
  endfunction

  function automatic logic [EW-1:0] pack2(input logic m1, input logic [ENTRYB-1:0] e1,
                                          input logic m0, input logic [ENTRYB-1:0] e0);
    return {m1, m0, e1[17:14], e0[17:14], e1[13:9], e0[13:9], e1[8:0], e0[8:0]};
  endfunction

  // Expected lookup result from the model, per the pid->LUT mapping rule.
  function automatic logic [EW-1:0] exp_lookup(input logic [NCH*MXPIDB-1:0] pv,
                                               input logic [NCH*MXADRB-1:0] cv);
    logic [NCH-1:0]    m;
    logic [ENTRYB-1:0] e [NCH];
    int                p;
    for (int c = 0; c < NCH; c++) begin
      p = int'(pv[c*MXPIDB +: MXPIDB]);
      if (p < PID_BASE || p >= PID_BASE + NPID) begin
        m[c] = 1'b1;
        e[c] = '0;
      end else begin
        m[c] = 1'b0;
        e[c] = model[p - PID_BASE][cv[c*MXADRB +: MXADRB]];
      end
    end
    return pack2(m[1], e[1], m[0], e[0]);
  endfunction

  always @(negedge clock) begin
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", out_valid, 1'b0);
      else begin
        chk("lookup", {pid_miss, offs, bend, quality}, exp_q.pop_front());
        chk("latency", cyc, iss_q.pop_front() + 2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_lookup(input logic [NCH*MXPIDB-1:0] pv, input logic [NCH*MXADRB-1:0] cv,
                              input logic [EW-1:0] ev);
    in_valid = 1'b1;
    pid      = pv;
    carry    = cv;
    exp_q.push_back(ev);
    iss_q.push_back(cyc);
  endtask

  task automatic wait_init(input bit noise);
    int n = 0, acks = 0, vals = 0;
    while (init_busy && n < 5000) begin
      if (noise) begin
        in_valid     = 1'($urandom_range(0, 1));
        pid          = (NCH*MXPIDB)'($urandom);
        carry        = (NCH*MXADRB)'($urandom);
        hif.host_req = (n < 4000);
        hif.host_wr  = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      n++;
      acks += int'(hif.host_ack);
      vals += int'(out_valid);
    end
    in_valid     = 1'b0;
    hif.host_req = 1'b0;
    chk("init_cycles", n, DEPTH);
    chk("init_no_ack", acks, 0);
    chk("init_no_out_valid", vals, 0);
    @(negedge clock);
  endtask

  task automatic host_write(input logic [2:0] lut, input logic [MXADRB-1:0] adr,
                            input logic [ENTRYB-1:0] d);
    int   n = 0;
    logic got = 1'b0;
    hif.host_req = 1'b1; hif.host_wr = 1'b1;
    hif.host_lut = lut;  hif.host_adr = adr; hif.host_wdata = d;
    while (!got && n < 10) begin
      @(negedge clock);
      n++;
      got = hif.host_ack;
    end
    chk("wr_ack", got, 1'b1);
    if (int'(lut) < NPID) model[lut][adr] = stored(d);
    hif.host_req = 1'b0;
    @(negedge clock);
    chk("wr_ack_pulse", hif.host_ack, 1'b0);
  endtask

  task automatic host_read(input logic [2:0] lut, input logic [MXADRB-1:0] adr, input int hold);
    int   n = 0;
    logic got = 1'b0;
    logic [ENTRYB-1:0] expd;
    expd = (int'(lut) < NPID) ? model[lut][adr] : '0;
    hif.host_req = 1'b1; hif.host_wr = 1'b0;
    hif.host_lut = lut;  hif.host_adr = adr;
    while (!got && n < 10) begin
      @(negedge clock);
      n++;
      got = hif.host_ack;
    end
    chk("rd_ack", got, 1'b1);
    chk("rd_data", hif.host_rdata, expd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("rd_held_req_no_ack", hif.host_ack, 1'b0);
    end
    hif.host_req = 1'b0;
    @(negedge clock);
    chk("rd_ack_pulse", hif.host_ack, 1'b0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [NCH*MXPIDB-1:0] pv;
    logic [NCH*MXADRB-1:0] cv;
    logic [EW-1:0]         ev;
  } vec_t;

  vec_t              tbl [6];
  logic [MXADRB-1:0] pool [8];
  logic [ENTRYB-1:0] def_e, w_e, n_e, z_e, c_e;
  logic [NCH*MXPIDB-1:0] pv;
  logic [NCH*MXADRB-1:0] cv;
  int acks;

  initial begin
    def_e = {4'd7, 5'd0, 9'd0};
    w_e   = {4'hB, 5'h13, 9'h1A5};
    n_e   = {4'h2, 5'h0A, 9'h0C3};
    c_e   = {4'h3, 5'h1C, 9'h0F0};
    z_e   = '0;
    pool  = '{12'h000, 12'h001, 12'h010, 12'h456, 12'h7FF, 12'h800, 12'hABC, 12'hFFF};
    tbl[0] = '{{4'h8, 4'h8}, {12'h123, 12'h123}, pack2(1'b0, stored(w_e), 1'b0, stored(w_e))};
    tbl[1] = '{{4'h8, 4'h5}, {12'h123, 12'h123}, pack2(1'b0, stored(w_e), 1'b1, z_e)};
    tbl[2] = '{{4'h6, 4'hB}, {12'h456, 12'h123}, pack2(1'b0, def_e, 1'b1, z_e)};
    tbl[3] = '{{4'h9, 4'hA}, {12'h000, 12'hFFF}, pack2(1'b0, def_e, 1'b0, def_e)};
    tbl[4] = '{{4'h7, 4'h8}, {12'h123, 12'h123}, pack2(1'b0, def_e, 1'b0, stored(w_e))};
    tbl[5] = '{{4'hF, 4'h0}, {12'h123, 12'h123}, pack2(1'b1, z_e, 1'b1, z_e)};

    in_valid = 1'b0; pid = '0; carry = '0;
    hif.host_req = 1'b0; hif.host_wr = 1'b0; hif.host_lut = '0;
    hif.host_adr = '0;   hif.host_wdata = '0;
    model_reset();

    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_init_busy", init_busy, 1'b1);
    chk("rst_host_ack", hif.host_ack, 1'b0);
    chk("rst_host_rdata", hif.host_rdata, '0);
    chk("rst_fields", {pid_miss, offs, bend, quality}, '0);
    reset_n = 1'b1;
    wait_init(1'b1);
    chk("init_done", init_busy, 1'b0);

    // Default contents after init, random pids inside the mapped range.
    for (int i = 0; i < 20; i++) begin
      pv = {4'($urandom_range(6, 10)), 4'($urandom_range(6, 10))};
      cv = (NCH*MXADRB)'($urandom);
      drive_lookup(pv, cv, exp_lookup(pv, cv));
      @(negedge clock);
    end
    in_valid = 1'b0;

    host_write(3'd2, 12'h123, w_e);
    for (int i = 0; i < 6; i++) begin
      drive_lookup(tbl[i].pv, tbl[i].cv, tbl[i].ev);
      @(negedge clock);
    end
    in_valid = 1'b0;

    // Reads: held request served once, rdata held across a write, unmapped LUTs.
    host_read(3'd2, 12'h123, 3);
    host_write(3'd2, 12'h123, n_e);
    chk("rdata_held_after_write", hif.host_rdata, stored(w_e));
    host_read(3'd6, 12'h123, 0);
    host_read(3'd2, 12'h123, 0);
    host_read(3'd5, 12'h001, 0);

    // Same-cycle host write and lookup: read-first, next cycle sees new data.
    hif.host_req = 1'b1; hif.host_wr = 1'b1; hif.host_lut = 3'd0;
    hif.host_adr = 12'h010; hif.host_wdata = c_e;
    @(negedge clock);
    pv = {4'h6, 4'h6}; cv = {12'h010, 12'h010};
    drive_lookup(pv, cv, exp_lookup(pv, cv));
    @(negedge clock);
    chk("coll_ack", hif.host_ack, 1'b1);
    model[0][12'h010] = stored(c_e);
    drive_lookup(pv, cv, exp_lookup(pv, cv));
    @(negedge clock);
    in_valid = 1'b0; hif.host_req = 1'b0;
    @(negedge clock);

    // Randomized host writes (including unmapped LUTs), lookups and reads.
    for (int i = 0; i < 24; i++)
      host_write(3'($urandom_range(0, 6)), pool[$urandom_range(0, 7)], ENTRYB'($urandom));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        pv = {4'($urandom_range(3, 12)), 4'($urandom_range(3, 12))};
        cv = {pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)]};
        drive_lookup(pv, cv, exp_lookup(pv, cv));
      end else in_valid = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++)
      host_read(3'($urandom_range(0, 6)), pool[$urandom_range(0, 7)], 0);
    repeat (4) @(negedge clock);

    // Reset in the middle of a host write, with a lookup in flight.
    hif.host_req = 1'b1; hif.host_wr = 1'b1; hif.host_lut = 3'd3;
    hif.host_adr = 12'h055; hif.host_wdata = {4'h1, 5'h11, 9'h111};
    in_valid = 1'b1; pid = {4'h8, 4'h8}; carry = {12'h123, 12'h123};
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clock);
      acks += int'(hif.host_ack);
    end
    chk("reset_abort_no_ack", acks, 0);
    chk("reset_init_busy", init_busy, 1'b1);
    chk("reset_rdata", hif.host_rdata, '0);
    hif.host_req = 1'b0;
    model_reset();
    reset_n = 1'b1;
    wait_init(1'b0);
    host_read(3'd3, 12'h055, 0);
    host_read(3'd2, 12'h123, 0);
    pv = {4'h8, 4'h6}; cv = {12'h123, 12'h010};
    drive_lookup(pv, cv, exp_lookup(pv, cv));
    @(negedge clock);
    in_valid = 1'b0;

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
